// File: rtl/neokeon_rc_seq_if.sv
// Handshake bundle between the Noekeon round-constant sequencer and the round controller.
// The sequencer takes the slave side; the controller (or a bench) takes the master side.
interface neokeon_rc_seq_if;
    logic       inStart;
    logic       inDecrypt;
    logic       inStep;
    logic       inAbort;
    logic [7:0] outRc;
    logic [4:0] outRound;
    logic       outValid;
    logic       outLast;
    logic       outBusy;
    logic       outDone;

    modport master (
        output inStart,
        output inDecrypt,
        output inStep,
        output inAbort,
        input  outRc,
        input  outRound,
        input  outValid,
        input  outLast,
        input  outBusy,
        input  outDone
    );

    modport slave (
        input  inStart,
        input  inDecrypt,
        input  inStep,
        input  inAbort,
        output outRc,
        output outRound,
        output outValid,
        output outLast,
        output outBusy,
        output outDone
    );
endinterface

// File: rtl/neokeon_rc_seq.sv
// Sequential Noekeon round-constant generator: walks GF(2^8) doubling forward for
// encryption or its exact inverse for decryption, one constant per accepted step.
module neokeon_rc_seq #(
    parameter int         ROUNDS      = 16,
    parameter logic [7:0] RC_ENC_INIT = 8'h80,
    parameter logic [7:0] RC_DEC_INIT = 8'hD4
) (
    input logic              inClk,
    input logic              inRst,
    neokeon_rc_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

    state_t     state, stateNext;
    logic [7:0] rc, rcNext;
    logic [4:0] round, roundNext;
    logic       decrypt, decryptNext;
    logic [7:0] rcForward, rcInverse;

    // Inverse undoes the doubling: an odd value means the reduction polynomial was folded in.
    always_comb begin
        rcForward = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
        rcInverse = rc[0] ? (8'h80 | ((rc ^ 8'h1B) >> 1)) : (rc >> 1);
    end

    always_ff @(posedge inClk) begin
        if (inRst) begin
            state   <= IDLE;
            rc      <= 8'h00;
            round   <= 5'd0;
            decrypt <= 1'b0;
        end else begin
            state   <= stateNext;
            rc      <= rcNext;
            round   <= roundNext;
            decrypt <= decryptNext;
        end
    end

    always_comb begin
        stateNext   = state;
        rcNext      = rc;
        roundNext   = round;
        decryptNext = decrypt;
        unique case (state)
            IDLE: begin
                if (!bus.inAbort && bus.inStart) begin
                    stateNext   = RUN;
                    decryptNext = bus.inDecrypt;
                    rcNext      = bus.inDecrypt ? RC_DEC_INIT : RC_ENC_INIT;
                    roundNext   = 5'd0;
                end
            end
            RUN: begin
                if (bus.inAbort) begin
                    stateNext   = IDLE;
                    rcNext      = 8'h00;
                    roundNext   = 5'd0;
                    decryptNext = 1'b0;
                end else if (bus.inStep) begin
                    if (round == LAST_ROUND) begin
                        stateNext = DONE;
                    end else begin
                        rcNext    = decrypt ? rcInverse : rcForward;
                        roundNext = round + 5'd1;
                    end
                end
            end
            DONE: begin
                stateNext = IDLE;
                if (bus.inAbort) begin
                    rcNext      = 8'h00;
                    roundNext   = 5'd0;
                    decryptNext = 1'b0;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // An aborted DONE cycle must not be seen as a completed sequence.
    always_comb begin
        bus.outRc    = rc;
        bus.outRound = round;
        bus.outValid = (state == RUN);
        bus.outBusy  = (state == RUN);
        bus.outLast  = (state == RUN) && (round == LAST_ROUND);
        bus.outDone  = (state == DONE) && !bus.inAbort;
    end

endmodule
